// File: rtl/cursor_ctrl.sv
// -----------------------------------------------------------------------------
// cursor_ctrl
//
// Purpose:
//   Moves a cursor over a GRID_COLS x GRID_ROWS board from debounced button
//   pulses, with wrap-around at every edge. It also turns center presses into
//   action requests:
//     - a single click produces a reveal (type 0);
//     - a second click inside the double-click window produces a flag toggle
//       (type 1).
//   The action carries the cursor position as it was at the first click. It is
//   held with a valid/ready handshake until the consumer accepts it.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   btn_pulse_i  one-cycle pulses: [0] up, [1] down, [2] left, [3] right,
//                [4] center
//   cur_x_o      current cursor column (registered)
//   cur_y_o      current cursor row (registered)
//   act_valid_o  action request valid (registered)
//   act_type_o   0 = reveal, 1 = flag toggle
//   act_x_o      action column
//   act_y_o      action row
//   act_ready_i  consumer accepts the action when high together with valid
// -----------------------------------------------------------------------------
module cursor_ctrl #(
    parameter int GRID_COLS   = 16,
    parameter int GRID_ROWS   = 16,
    parameter int DCLICK_WAIT = 25_000_000,
    localparam int XW = $clog2(GRID_COLS),
    localparam int YW = $clog2(GRID_ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    btn_pulse_i,
    output logic [XW-1:0] cur_x_o,
    output logic [YW-1:0] cur_y_o,
    output logic          act_valid_o,
    output logic          act_type_o,
    output logic [XW-1:0] act_x_o,
    output logic [YW-1:0] act_y_o,
    input  logic          act_ready_i
);

    // The window counter only has to reach DCLICK_WAIT-1. WAIT2 is left on
    // that value, so the counter can never wrap.
    localparam int            CW       = $clog2(DCLICK_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DCLICK_WAIT - 1);
    localparam logic [XW-1:0] X_MAX    = XW'(GRID_COLS - 1);
    localparam logic [YW-1:0] Y_MAX    = YW'(GRID_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT2 = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [XW-1:0] cur_x_q, cur_x_d;
    logic [YW-1:0] cur_y_q, cur_y_d;
    logic [XW-1:0] lat_x_q;
    logic [YW-1:0] lat_y_q;
    logic          act_valid_q;
    logic          act_type_q;
    logic [XW-1:0] act_x_q;
    logic [YW-1:0] act_y_q;

    logic btn_up, btn_down, btn_left, btn_right, btn_center, any_dir;

    assign btn_up     = btn_pulse_i[0];
    assign btn_down   = btn_pulse_i[1];
    assign btn_left   = btn_pulse_i[2];
    assign btn_right  = btn_pulse_i[3];
    assign btn_center = btn_pulse_i[4];
    // Any direction bit ends a pending single click, even a pair that cancels.
    assign any_dir    = |btn_pulse_i[3:0];

    // Next cursor position. Opposite directions in the same cycle cancel.
    // The grid size may not be a power of two, so wrap uses explicit compares.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        cur_x_d = cur_x_q;
        cur_y_d = cur_y_q;
        if (btn_right && !btn_left) begin
            cur_x_d = (cur_x_q == X_MAX) ? '0 : cur_x_q + XW'(1);
        end else if (btn_left && !btn_right) begin
            cur_x_d = (cur_x_q == '0) ? X_MAX : cur_x_q - XW'(1);
        end
        if (btn_down && !btn_up) begin
            cur_y_d = (cur_y_q == Y_MAX) ? '0 : cur_y_q + YW'(1);
        end else if (btn_up && !btn_down) begin
            cur_y_d = (cur_y_q == '0) ? Y_MAX : cur_y_q - YW'(1);
        end
    end

    // Click FSM. The action outputs are loaded only when HOLD is entered, so
    // they keep their last values everywhere else.
    always_ff @(posedge clk) begin
        // NOTE: all state here is written with non-blocking assignments.
        // Every register then samples pre-edge values, and the order of the
        // statements does not matter.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_x_q     <= '0;
            cur_y_q     <= '0;
            lat_x_q     <= '0;
            lat_y_q     <= '0;
            act_valid_q <= 1'b0;
            act_type_q  <= 1'b0;
            act_x_q     <= '0;
            act_y_q     <= '0;
        end else begin
            // Cursor moves are accepted in every state.
            cur_x_q <= cur_x_d;
            cur_y_q <= cur_y_d;

            case (state_q)
                IDLE: begin
                    if (btn_center) begin
                        // Latch the position from before this cycle's move.
                        lat_x_q <= cur_x_q;
                        lat_y_q <= cur_y_q;
                        cnt_q   <= '0;
                        state_q <= WAIT2;
                    end
                end

                WAIT2: begin
                    if (btn_center) begin
                        // A second click wins, even on the last window cycle.
                        act_valid_q <= 1'b1;
                        act_type_q  <= 1'b1;
                        act_x_q     <= lat_x_q;
                        act_y_q     <= lat_y_q;
                        state_q     <= HOLD;
                    end else if (cnt_q == CNT_LAST || any_dir) begin
                        act_valid_q <= 1'b1;
                        act_type_q  <= 1'b0;
                        act_x_q     <= lat_x_q;
                        act_y_q     <= lat_y_q;
                        state_q     <= HOLD;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end

                HOLD: begin
                    // Center pulses are ignored here, including during the
                    // handshake cycle.
                    if (act_ready_i) begin
                        act_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end

                default: begin
                    act_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cur_x_o     = cur_x_q;
    assign cur_y_o     = cur_y_q;
    assign act_valid_o = act_valid_q;
    assign act_type_o  = act_type_q;
    assign act_x_o     = act_x_q;
    assign act_y_o     = act_y_q;

endmodule

// File: tb/tb_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cursor_ctrl
//
// Self-checking bench for cursor_ctrl with DCLICK_WAIT=8 on a 16x16 grid.
// Three phases:
//   - a vector table of cursor moves and resets;
//   - hand-written click sequences with explicit cycle counts;
//   - a random run compared against a behavioural model.
// The model tracks the first-click time as an absolute cycle number and moves
// the cursor with modular arithmetic.
// -----------------------------------------------------------------------------
module tb_cursor_ctrl;

    localparam int COLS = 16;
    localparam int ROWS = 16;
    localparam int DW   = 8;

    localparam logic [4:0] B_NONE   = 5'b00000;
    localparam logic [4:0] B_UP     = 5'b00001;
    localparam logic [4:0] B_DOWN   = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b01000;
    localparam logic [4:0] B_CENTER = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] btn = '0;
    logic       ready = 1'b0;
    logic [3:0] cur_x, cur_y, act_x, act_y;
    logic       act_valid, act_type;

    int n_checks = 0;
    int n_fail   = 0;

    cursor_ctrl #(
        .GRID_COLS  (COLS),
        .GRID_ROWS  (ROWS),
        .DCLICK_WAIT(DW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_pulse_i(btn),
        .cur_x_o    (cur_x),
        .cur_y_o    (cur_y),
        .act_valid_o(act_valid),
        .act_type_o (act_type),
        .act_x_o    (act_x),
        .act_y_o    (act_y),
        .act_ready_i(ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    int m_cycle = 0;   // index of the clock edge about to happen
    int m_first = -1;  // edge index of the pending first click, -1 if none
    bit m_hold  = 0;   // an action is being offered
    int cx = 0, cy = 0, lx = 0, ly = 0;
    int m_type = 0, m_ax = 0, m_ay = 0;

    task automatic model_edge(input logic r, input logic [4:0] b, input logic rdy);
        int dx, dy, age;
        bit fire, flag;
        if (r) begin
            m_first = -1; m_hold = 0;
            cx = 0; cy = 0; m_type = 0; m_ax = 0; m_ay = 0;
        end else begin
            fire = 0; flag = 0;
            if (m_hold) begin
                if (rdy) m_hold = 0;
            end else if (m_first >= 0) begin
                age = m_cycle - m_first;
                if (b[4]) begin
                    fire = 1; flag = 1;
                end else if (age >= DW || b[3:0] != 4'b0) begin
                    fire = 1;
                end
            end else if (b[4]) begin
                m_first = m_cycle; lx = cx; ly = cy;
            end
            if (fire) begin
                m_hold = 1; m_first = -1;
                m_type = int'(flag); m_ax = lx; m_ay = ly;
            end
            dx = int'(b[3]) - int'(b[2]);
            dy = int'(b[1]) - int'(b[0]);
            cx = (cx + dx + COLS) % COLS;
            cy = (cy + dy + ROWS) % ROWS;
        end
        m_cycle++;
    endtask

    // Apply inputs for one clock and sample 1 time unit after the edge.
    task automatic step(input logic r, input logic [4:0] b, input logic rdy);
        rst = r; btn = b; ready = rdy;
        model_edge(r, b, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_act(input string name, input int v, input int t, input int x, input int y);
        check({name, ".valid"}, 32'(act_valid), v);
        check({name, ".act"}, 32'({act_type, act_x, act_y}), t * 256 + x * 16 + y);
    endtask

    task automatic check_cur(input string name, input int x, input int y);
        check({name, ".cur"}, 32'({cur_x, cur_y}), x * 16 + y);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       r;
        logic [4:0] b;
        int         ex;
        int         ey;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, B_NONE,           0,  0};
        vecs[1]  = '{1'b0, B_LEFT,          15,  0};
        vecs[2]  = '{1'b0, B_UP,            15, 15};
        vecs[3]  = '{1'b0, B_UP | B_DOWN,   15, 15};
        vecs[4]  = '{1'b0, B_LEFT | B_RIGHT, 15, 15};
        vecs[5]  = '{1'b0, B_UP | B_RIGHT,   0, 14};
        vecs[6]  = '{1'b0, B_DOWN | B_LEFT, 15, 15};
        vecs[7]  = '{1'b0, B_DOWN,          15,  0};
        vecs[8]  = '{1'b0, B_RIGHT,          0,  0};
        vecs[9]  = '{1'b1, B_RIGHT,          0,  0};
        vecs[10] = '{1'b0, B_UP | B_DOWN | B_LEFT, 15, 0};

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].r, vecs[i].b, 1'b0);
            check($sformatf("vec%0d", i), 32'({cur_x, cur_y}), vecs[i].ex * 16 + vecs[i].ey);
            check($sformatf("vec%0d.valid", i), 32'(act_valid), 0);
        end
        check_act("reset_act", 0, 0, 0, 0);

        // Single click at (3,4): valid exactly in cycle T+9, then back to IDLE.
        step(1'b1, B_NONE, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, B_RIGHT, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, B_DOWN, 1'b1);
        check_cur("single.pos", 3, 4);
        step(1'b0, B_CENTER, 1'b1);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("single.early%0d", i), 32'(act_valid), 0);
            step(1'b0, B_NONE, 1'b1);
        end
        check("single.early7", 32'(act_valid), 0);
        step(1'b0, B_NONE, 1'b1);
        check_act("single.hold", 1, 0, 3, 4);
        step(1'b0, B_NONE, 1'b1);
        check_act("single.done", 0, 0, 3, 4);
        step(1'b0, B_NONE, 1'b1);
        check("single.idle", 32'(act_valid), 0);

        // Double click: center at T and T+5, then backpressure with cursor moves.
        step(1'b1, B_NONE, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, B_NONE, 1'b0);
        check("double.before", 32'(act_valid), 0);
        step(1'b0, B_CENTER, 1'b0);
        check_act("double.hold", 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, B_RIGHT, 1'b0);
            check_act($sformatf("double.stall%0d", i), 1, 1, 0, 0);
        end
        check_cur("double.cur", 4, 0);
        step(1'b0, B_CENTER, 1'b1);
        check_act("double.accept", 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1'b0, B_NONE, 1'b0);
        check("double.no_new", 32'(act_valid), 0);

        // Boundary: the second center on the last window cycle gives a flag.
        step(1'b1, B_NONE, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, B_NONE, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        check_act("edge7.flag", 1, 1, 0, 0);
        step(1'b0, B_NONE, 1'b1);
        check("edge7.accept", 32'(act_valid), 0);

        // One cycle later the window is closed: a reveal is issued and the
        // center pulse that arrives in HOLD is ignored.
        step(1'b1, B_RIGHT, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, B_NONE, 1'b0);
        check_act("edge8.reveal", 1, 0, 0, 0);
        step(1'b0, B_CENTER, 1'b1);
        check("edge8.accept", 32'(act_valid), 0);
        for (int i = 0; i < 10; i++) step(1'b0, B_NONE, 1'b1);
        check("edge8.ignored", 32'(act_valid), 0);

        // Move during WAIT2 commits a reveal at the latched position.
        step(1'b1, B_NONE, 1'b0);
        step(1'b0, B_RIGHT | B_DOWN, 1'b0);
        step(1'b0, B_RIGHT | B_DOWN, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        step(1'b0, B_NONE, 1'b0);
        step(1'b0, B_NONE, 1'b0);
        check("move.wait", 32'(act_valid), 0);
        step(1'b0, B_RIGHT, 1'b0);
        check_act("move.reveal", 1, 0, 2, 2);
        check_cur("move.cur", 3, 2);
        step(1'b0, B_NONE, 1'b1);

        // Reset in the middle of HOLD drops the action.
        step(1'b0, B_CENTER, 1'b0);
        step(1'b0, B_CENTER, 1'b0);
        check_act("rsthold.hold", 1, 1, 3, 2);
        step(1'b0, B_NONE, 1'b0);
        step(1'b1, B_CENTER, 1'b0);
        check_act("rsthold.cleared", 0, 0, 0, 0);
        check_cur("rsthold.cur", 0, 0);
        for (int i = 0; i < 12; i++) begin
            step(1'b0, B_NONE, 1'b1);
            check($sformatf("rsthold.quiet%0d", i), 32'(act_valid), 0);
        end

        // Reset during WAIT2 discards the pending click.
        step(1'b0, B_CENTER, 1'b1);
        step(1'b0, B_NONE, 1'b1);
        step(1'b1, B_NONE, 1'b1);
        for (int i = 0; i < 12; i++) step(1'b0, B_NONE, 1'b1);
        check("rstwait.quiet", 32'(act_valid), 0);

        // Random stimulus against the model.
        step(1'b1, B_NONE, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            logic       r, rdy;
            b[0] = ($urandom_range(0, 7) == 0);
            b[1] = ($urandom_range(0, 7) == 0);
            b[2] = ($urandom_range(0, 7) == 0);
            b[3] = ($urandom_range(0, 7) == 0);
            b[4] = ($urandom_range(0, 4) == 0);
            rdy  = ($urandom_range(0, 2) == 0);
            r    = ($urandom_range(0, 299) == 0);
            step(r, b, rdy);
            check($sformatf("rand%0d.cur", i), 32'({cur_x, cur_y}), cx * 16 + cy);
            check($sformatf("rand%0d.valid", i), 32'(act_valid), int'(m_hold));
            check($sformatf("rand%0d.act", i), 32'({act_type, act_x, act_y}),
                  m_type * 256 + m_ax * 16 + m_ay);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cursor_ctrl.md
CURSOR_CTRL -- requirements
Module: cursor_ctrl

Interface
REQ-001 Parameter GRID_COLS, default 16, number of grid columns (2..256).
REQ-002 Parameter GRID_ROWS, default 16, number of grid rows (2..256).
REQ-003 Parameter DCLICK_WAIT, default 25_000_000, double-click window in clock cycles (>=2).
REQ-004 Port clk  input  1  single system clock; all state changes on posedge clk.
REQ-005 Port rst  input  1  synchronous active-high reset.
REQ-006 Port btn_pulse_i  input  5  debounced one-cycle button pulses: [0] up, [1] down, [2] left, [3] right, [4] center; several bits may be high in the same cycle.
REQ-007 Port cur_x_o  output  XW=$clog2(GRID_COLS)  current cursor column.
REQ-008 Port cur_y_o  output  YW=$clog2(GRID_ROWS)  current cursor row.
REQ-009 Port act_valid_o  output  1  action request valid.
REQ-010 Port act_type_o  output  1  0 = reveal, 1 = flag toggle.
REQ-011 Port act_x_o  output  XW  action column.
REQ-012 Port act_y_o  output  YW  action row.
REQ-013 Port act_ready_i  input  1  consumer accepts the action when high with act_valid_o.

Function
REQ-014 Cursor and action outputs SHALL be registered; cursor updates 1 cycle after the sampling pulse.
REQ-015 Up decrements cur_y_o and down increments it; up and down in the same cycle SHALL cancel (no vertical move).
REQ-016 Left decrements cur_x_o and right increments it; left and right in the same cycle SHALL cancel; one vertical plus one horizontal bit moves diagonally.
REQ-017 Moves SHALL wrap: x GRID_COLS-1 + right -> 0; x 0 + left -> GRID_COLS-1; y likewise with GRID_ROWS.
REQ-018 Cursor moves SHALL be accepted in every FSM state, including while an action is pending.
REQ-019 FSM states: IDLE, WAIT2, HOLD; reset state IDLE.
REQ-020 IDLE + center: latch the pre-move cursor (value before any move that cycle) as the action position, clear window counter, go to WAIT2.
REQ-021 WAIT2: counter increments each cycle starting from 0 on entry.
REQ-022 WAIT2 + center while counter <= DCLICK_WAIT-1: go to HOLD with act_type_o=1 at the latched position.
REQ-023 WAIT2 + counter == DCLICK_WAIT-1 with no center: go to HOLD with act_type_o=0; a center in that same cycle SHALL yield flag (flag wins).
REQ-024 WAIT2 + any direction bit with no center: commit reveal (HOLD, type 0) at the latched position in that cycle; the cursor moves as well.
REQ-025 HOLD: act_valid_o=1; act_type_o, act_x_o and act_y_o SHALL remain stable until the handshake.
REQ-026 HOLD + act_ready_i=1: handshake; act_valid_o deasserts next cycle; go to IDLE.
REQ-027 Center pulses in HOLD SHALL be ignored, including in the handshake cycle.
REQ-028 act_ready_i SHALL be ignored outside HOLD.
REQ-029 Outside HOLD, act_valid_o=0; act_type_o, act_x_o and act_y_o hold their last values.
REQ-030 Reveal timing: first center sampled at cycle T, no further input -> act_valid_o high from cycle T+DCLICK_WAIT+1.
REQ-031 Counter width SHALL be sufficient for DCLICK_WAIT-1 without overflow; it SHALL never wrap while in WAIT2.

Reset
REQ-032 With rst high at a clock edge: state IDLE, counter 0, cur_x_o=0, cur_y_o=0, act_valid_o=0, act_type_o=0, act_x_o=0, act_y_o=0.
REQ-033 Reset in WAIT2 or HOLD SHALL discard the pending action without emitting it.
REQ-034 Pulses sampled while rst is high SHALL be ignored.

Verification (DCLICK_WAIT=8, GRID 16x16)
REQ-035 Wrap: from (0,0) pulse left, then up -> cursor (15,0), then (15,15); up+down together -> no change.
REQ-036 Single click: cursor (3,4), center at cycle T, ready=1 -> act_valid_o high only at cycle T+9, type 0, (3,4); returns to IDLE.
REQ-037 Double click: center at T and T+5 -> valid from T+6, type 1; ready held 0 for 4 cycles -> outputs stable, then one-cycle accept.
REQ-038 Boundary: second center exactly at counter=7 -> flag; at counter=8 (already HOLD) -> ignored, reveal issued.
REQ-039 Move during WAIT2: center at (2,2), right 3 cycles later -> reveal at (2,2) next cycle, cursor (3,2).
REQ-040 Reset mid-HOLD: valid held, rst pulse -> act_valid_o=0 and cursor (0,0) the next cycle; no action emitted afterwards.
